wrr_req_buffer: RTL and testbench
=================================

# wrr_req_buffer

Per-requester ingress buffer that sits directly upstream of `wrr_arbiter`. It holds up to DEPTH entries per port and presents a non-empty port as a request. When the arbiter grants a port, it pops that port's head entry into a single registered output stage with valid/ready backpressure. The block is the request source and data path that the weighted round-robin arbiter schedules.

## Interface
- `WIDTH`, 2, number of requester ports (matches arbiter WIDTH).
- `DATA_WIDTH`, 8, payload bits per entry.
- `DEPTH`, 4, entries per port FIFO; power of two, ≥2. AW = $clog2(DEPTH).

Ports:
- `clk` in 1, single clock, all state on rising edge.
- `rst` in 1, asynchronous, active-high reset.
- `in_valid` in WIDTH, per-port push request.
- `in_data` in WIDTH*DATA_WIDTH, per-port payload; port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `in_ready` out WIDTH, per-port space available.
- `req` out WIDTH, request vector to the arbiter `req`.
- `grant` in WIDTH, grant vector from the arbiter `grant`, same cycle as `req`.
- `out_valid` out 1, output register holds an entry.
- `out_data` out DATA_WIDTH, popped payload.
- `out_grant` out WIDTH, one-hot source port of `out_data`.
- `out_ready` in 1, downstream accepts `out_data`.

## Operation
- Each port has a FIFO with a read pointer and a write pointer, each AW bits wide and wrapping modulo DEPTH, plus a count cnt[i] in the range 0..DEPTH (AW+1 bits).
- `in_ready[i]` = (cnt[i] != DEPTH) & ~rst.
  - push[i] = in_valid[i] & in_ready[i].
  - No push when the FIFO is full, even if a pop occurs in the same cycle (no full-pop bypass).
- advance = ~out_valid | out_ready.
- `req[i]` = (cnt[i] != 0) & advance & ~rst. The block withholds all requests while the output register is stalled.
- pop selection:
  - g = grant & req. Bits of `grant` with no matching `req` are ignored.
  - If g is multi-hot (arbiter protocol violation), only the lowest set index pops.
  - pop[i] is that selected bit.
- Same-port push and pop in one cycle: cnt is unchanged, both pointers advance, and FIFO order is preserved.
- No empty-FIFO bypass: a pushed entry is visible to `req` only after it is written.
- Output register:
  - On any pop: out_valid←1, out_data←head of the popped port, out_grant←one-hot(pop).
  - Else if out_ready: out_valid←0. out_data and out_grant hold their values.
  - While out_valid=1 and out_ready=0, out_data and out_grant are stable.
- Reset (async, any time, including mid-transfer):
  - All cnt, pointers, out_valid, out_data and out_grant go to 0.
  - FIFO storage is not cleared.
  - in_ready and req are 0 while rst is high.
  - All in-flight entries are discarded.

## Timing
- Push accepted at edge N; cnt and req update in cycle N+1.
- Arbiter grant is combinational in cycle N+1, so the pop happens at edge N+1 and out_valid=1 in cycle N+2.
- Minimum ingress-to-output latency: 2 cycles.
- Throughput is one pop per cycle across all ports while out_ready=1.
- in_ready[i] drops in the cycle after the push that fills the port, and rises in the cycle after the pop that frees a slot.
- Output transfer completes on a cycle where out_valid & out_ready. A new pop may load the register in that same cycle.

## Test plan
- Reset:
  - During and right after rst, expect out_valid=0, out_data=0, out_grant=00, req=00 (0 while rst high).
  - After release with empty FIFOs, expect in_ready=11 and req=00.
  - Assert rst mid-traffic with cnt[0]=3 and out_valid=1; expect everything immediately zero and req=00 after release.
- Single entry:
  - Push port0 0xA5 at edge N; expect req=01 in N+1.
  - Drive grant=01 in N+1; expect out_valid=1, out_data=0xA5, out_grant=01 in N+2, req=00, cnt[0]=0.
- Full and wrap:
  - Push port1 with 0x10..0x13; expect in_ready[1]=0 after the 4th push, and a 5th push of 0x14 dropped.
  - Drain with grant=10; expect outputs 0x10..0x13 in order.
  - Repeat to cover 6+ entries through pointer wrap-around.
- Backpressure:
  - Set out_valid=1, out_ready=0, cnt[0]=2, grant=01; expect req=00, no pop, out_data stable.
  - Raise out_ready; expect req=01 in the same cycle and the next entry loaded.
- Simultaneous push and pop:
  - With cnt[1]=2, push 0x33 and grant=10 in the same cycle; expect cnt[1] stays 2 and 0x33 output after the two older entries.
- Grant filtering:
  - With req=01 and grant=10, expect no pop.
  - With req=11 and illegal grant=11, expect only port0 popped and out_grant=01.

Source files
------------

// File: rtl/wrr_req_buffer.sv
// Per-port ingress FIFOs feeding a weighted round-robin arbiter; the granted
// port's head entry is popped into a single registered valid/ready output stage.
module wrr_req_buffer #(
  parameter int WIDTH      = 2,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            in_valid,
  input  logic [WIDTH*DATA_WIDTH-1:0] in_data,
  output logic [WIDTH-1:0]            in_ready,
  output logic [WIDTH-1:0]            req,
  input  logic [WIDTH-1:0]            grant,
  output logic                        out_valid,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [WIDTH-1:0]            out_grant,
  input  logic                        out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem    [WIDTH][DEPTH];
  logic [AW-1:0]         r_rd_ptr [WIDTH];
  logic [AW-1:0]         r_wr_ptr [WIDTH];
  logic [AW:0]           r_cnt    [WIDTH];
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0]      r_out_grant;

  logic                  w_advance;
  logic [WIDTH-1:0]      w_push;
  logic [WIDTH-1:0]      w_grant_req;
  logic [WIDTH-1:0]      w_pop;
  logic [DATA_WIDTH-1:0] w_pop_data;

  // Requests are withheld entirely while the output register is stalled.
  assign w_advance = ~r_out_valid | out_ready;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    in_ready = '0;
    req      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      in_ready[i] = (r_cnt[i] != CNT_FULL) & ~rst;
      req[i]      = (r_cnt[i] != '0) & w_advance & ~rst;
    end
  end

  assign w_push      = in_valid & in_ready;
  assign w_grant_req = grant & req;
  // Isolate the lowest set bit so an illegal multi-hot grant pops one port only.
  assign w_pop       = w_grant_req & (~w_grant_req + 1'b1);

  always_comb begin
    w_pop_data = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_pop[i]) w_pop_data = r_mem[i][r_rd_ptr[i]];
    end
  end

  // NOTE: storage has no reset; cleared pointers and counts make stale contents unreachable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (w_push[i]) r_mem[i][r_wr_ptr[i]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_rd_ptr[i] <= '0;
        r_wr_ptr[i] <= '0;
        r_cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
        if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
        if (w_push[i] && !w_pop[i])      r_cnt[i] <= r_cnt[i] + 1'b1;
        else if (!w_push[i] && w_pop[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_grant <= '0;
    end else if (|w_pop) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_pop_data;
      r_out_grant <= w_pop;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_grant = r_out_grant;

endmodule

// File: tb/tb_wrr_req_buffer.sv
// Directed bench for wrr_req_buffer: reset, single entry, full/wrap, backpressure,
// simultaneous push/pop, grant filtering and mid-traffic reset.
module tb_wrr_req_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_valid;
  logic [15:0] in_data;
  logic [1:0]  in_ready;
  logic [1:0]  req;
  logic [1:0]  grant;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_grant;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  wrr_req_buffer #(.WIDTH(2), .DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .req       (req),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_grant (out_grant),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then land 2 time units later to drive new inputs.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic [1:0] g);
    check({tag, "_valid"}, 16'(out_valid), 16'd1);
    check({tag, "_data"},  16'(out_data),  16'(d));
    check({tag, "_grant"}, 16'(out_grant), 16'(g));
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; grant = '0; out_ready = 1'b1;

    // Reset state while rst is high
    #2;
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_data",  16'(out_data),  16'd0);
    check("rst_out_grant", 16'(out_grant), 16'd0);
    check("rst_req",       16'(req),       16'd0);
    check("rst_in_ready",  16'(in_ready),  16'd0);
    step(); step();
    rst = 1'b0;
    settle();
    check("post_rst_in_ready", 16'(in_ready), 16'b11);
    check("post_rst_req",      16'(req),      16'b00);

    // Single entry on port0: req one cycle after push, output one cycle after grant
    in_valid = 2'b01; in_data = {8'h00, 8'hA5};
    step();
    in_valid = 2'b00;
    settle();
    check("single_req", 16'(req), 16'b01);
    grant = 2'b01;
    step();
    grant = 2'b00;
    settle();
    check_out("single_out", 8'hA5, 2'b01);
    check("single_req_empty", 16'(req), 16'b00);
    step();
    settle();
    check("single_drain_valid", 16'(out_valid), 16'd0);

    // Fill port1 with 0x10..0x13, then a dropped 0x14
    for (int k = 0; k < 4; k++) begin
      in_valid = 2'b10; in_data = {8'(8'h10 + k), 8'h00};
      step();
    end
    settle();
    check("full_in_ready", 16'(in_ready), 16'b01);
    in_valid = 2'b10; in_data = {8'h14, 8'h00};
    step();
    in_valid = 2'b00;
    settle();
    check("full_req", 16'(req), 16'b10);
    grant = 2'b10;
    step(); settle();
    check_out("drain0", 8'h10, 2'b10);
    check("drain0_in_ready", 16'(in_ready), 16'b11);
    step(); settle(); check("drain1_data", 16'(out_data), 16'h11);
    step(); settle(); check("drain2_data", 16'(out_data), 16'h12);
    step(); settle(); check("drain3_data", 16'(out_data), 16'h13);
    check("drain_empty_req", 16'(req), 16'b00);
    grant = 2'b00;
    step(); settle();
    check("drop_no_fifth", 16'(out_valid), 16'd0);

    // Simultaneous push/pop on port1 with cnt=2, then a wrapping refill
    in_valid = 2'b10; in_data = {8'h31, 8'h00}; step();
    in_data = {8'h32, 8'h00}; step();
    in_data = {8'h33, 8'h00}; grant = 2'b10;
    step();
    in_valid = 2'b00;
    settle();
    check_out("simul_out", 8'h31, 2'b10);
    check("simul_req", 16'(req), 16'b10);
    step(); settle(); check("simul_next_data", 16'(out_data), 16'h32);
    step(); settle(); check("simul_pushed_data", 16'(out_data), 16'h33);
    check("simul_empty_req", 16'(req), 16'b00);
    grant = 2'b00;
    for (int k = 0; k < 3; k++) begin
      in_valid = 2'b10; in_data = {8'(8'h34 + k), 8'h00};
      step();
    end
    in_valid = 2'b00; grant = 2'b10;
    step(); settle(); check("wrap0_data", 16'(out_data), 16'h34);
    step(); settle(); check("wrap1_data", 16'(out_data), 16'h35);
    step(); settle(); check("wrap2_data", 16'(out_data), 16'h36);
    check("wrap_empty_req", 16'(req), 16'b00);
    grant = 2'b00;
    step();

    // Backpressure: stalled output withholds requests and holds its data
    for (int k = 0; k < 3; k++) begin
      in_valid = 2'b01; in_data = {8'h00, 8'(8'h40 + k)};
      step();
    end
    in_valid = 2'b00; out_ready = 1'b0; grant = 2'b01;
    step(); settle();
    check_out("bp_first", 8'h40, 2'b01);
    check("bp_req_withheld", 16'(req), 16'b00);
    step(); settle();
    check_out("bp_stable", 8'h40, 2'b01);
    out_ready = 1'b1;
    settle();
    check("bp_req_resume", 16'(req), 16'b01);
    step(); settle(); check("bp_next_data", 16'(out_data), 16'h41);
    step(); settle(); check("bp_last_data", 16'(out_data), 16'h42);
    grant = 2'b00;
    step(); settle();
    check("bp_idle_valid", 16'(out_valid), 16'd0);

    // Grant filtering: unmatched grant ignored, multi-hot grant pops lowest port
    in_valid = 2'b01; in_data = {8'h00, 8'h50};
    step();
    in_valid = 2'b00; grant = 2'b10;
    step(); settle();
    check("gf_no_pop_valid", 16'(out_valid), 16'd0);
    check("gf_no_pop_req",   16'(req),       16'b01);
    grant = 2'b00; in_valid = 2'b10; in_data = {8'h60, 8'h00};
    step();
    in_valid = 2'b00;
    settle();
    check("gf_both_req", 16'(req), 16'b11);
    grant = 2'b11;
    step(); settle();
    check_out("gf_multi", 8'h50, 2'b01);
    check("gf_multi_req", 16'(req), 16'b10);
    grant = 2'b10;
    step(); settle();
    check_out("gf_port1", 8'h60, 2'b10);
    grant = 2'b00;
    step();

    // Mid-traffic reset with cnt[0]=3 and a stalled output entry
    for (int k = 0; k < 4; k++) begin
      in_valid = 2'b01; in_data = {8'h00, 8'(8'h70 + k)};
      step();
    end
    in_valid = 2'b00; out_ready = 1'b0; grant = 2'b01;
    step();
    grant = 2'b00;
    settle();
    check_out("mid_pre_rst", 8'h70, 2'b01);
    rst = 1'b1;
    settle();
    check("mid_rst_out_valid", 16'(out_valid), 16'd0);
    check("mid_rst_out_data",  16'(out_data),  16'd0);
    check("mid_rst_out_grant", 16'(out_grant), 16'd0);
    check("mid_rst_req",       16'(req),       16'd0);
    check("mid_rst_in_ready",  16'(in_ready),  16'd0);
    step();
    rst = 1'b0; out_ready = 1'b1;
    settle();
    check("mid_post_req",      16'(req),       16'b00);
    check("mid_post_in_ready", 16'(in_ready),  16'b11);
    step(); settle();
    check("mid_post_req2",     16'(req),       16'b00);
    check("mid_post_valid",    16'(out_valid), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
